sram_b_stream_reader: RTL and testbench

Read-side streaming initiator for the 10-address-bit, 8-bit, one-write/one-read SRAM wrapper (`unisim_sram_b_10abits`). It accepts a burst descriptor (start address, length) and drives only the wrapper's read port (CE1/A1/Q1). It absorbs the one-cycle read latency and returns the words in address order on a valid/ready stream with last-beat marking. It sits between the accelerator datapath and the private local memory; writes stay on the wrapper's port 0 and are never driven by this block.

---
 rtl/sram_b_stream_reader.sv | 117 +++++++++++
 tb/tb_sram_b_stream_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_b_stream_reader.sv
// Burst read initiator for the 1W/1R SRAM wrapper: issues reads on the read
// port only and returns words in address order on a valid/ready stream.
module sram_b_stream_reader #(
  parameter int ABITS = 10,
  parameter int DBITS = 8,
  parameter int LBITS = 11
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [LBITS-1:0] req_len,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [ABITS-1:0] rd_addr;
  logic [LBITS-1:0] issue_rem, beat_rem;
  logic [1:0]       cnt, occ;
  logic             inflight;
  logic [DBITS-1:0] buf_mem [2];
  logic             head, tail;
  logic             accept, pop, push, issue, done_nxt;

  assign req_ready = (state == IDLE) & ~RST;
  assign accept    = req_valid & req_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = buf_mem[head];
  assign out_last  = out_valid & (beat_rem == LBITS'(1));
  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  // Reads in flight count against the buffer so a capture always has a slot.
  assign occ       = cnt + {1'b0, inflight};
  assign busy      = (state != IDLE);
  assign CE1       = issue;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    A1        = '0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_len == '0) done_nxt = 1'b1;
          else               state_nxt = RUN;
        end
      end
      RUN: begin
        A1    = rd_addr;
        issue = (issue_rem != '0) & ((occ < 2'd2) | ((occ == 2'd2) & pop));
        if (issue && issue_rem == LBITS'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      rd_addr    <= '0;
      issue_rem  <= '0;
      beat_rem   <= '0;
      cnt        <= '0;
      inflight   <= 1'b0;
      head       <= 1'b0;
      tail       <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      done       <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      done     <= done_nxt;
      if (issue) begin
        rd_addr   <= rd_addr + ABITS'(1);
        issue_rem <= issue_rem - LBITS'(1);
      end
      if (pop) begin
        head     <= ~head;
        beat_rem <= beat_rem - LBITS'(1);
      end
      if (push) begin
        buf_mem[tail] <= Q1;
        tail          <= ~tail;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (accept) begin
        rd_addr   <= req_addr;
        issue_rem <= req_len;
        beat_rem  <= req_len;
      end
    end
  end

endmodule

// File: tb/tb_sram_b_stream_reader.sv
// Randomized bench for sram_b_stream_reader with an SRAM model and a
// burst-level reference (expected word list, outstanding-read count).
module tb_sram_b_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [9:0]  req_addr;
  logic [10:0] req_len;
  logic        ce1;
  logic [9:0]  a1;
  logic [7:0]  q1 = 8'h00;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        out_last, busy, done;

  always #5 clk = ~clk;

  sram_b_stream_reader dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .CE1(ce1), .A1(a1), .Q1(q1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  logic [7:0] mem [1024];
  always @(posedge clk) if (ce1) q1 <= mem[a1];

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state for the burst in progress
  logic [7:0] exp_q [$];
  int b_addr, b_len, issued, popped, done_cnt;
  int cyc = 0, kk, first_pop, last_cyc, done_cyc;
  bit running = 0, hold = 0;
  logic [7:0] hold_data;

  function automatic logic pick(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: case (k % 6)
           0, 3, 5: return 1'b1;
           default: return 1'b0;
         endcase
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Sampled mid-cycle: compare outputs with the burst model, then advance it.
  task automatic observe();
    logic p;
    int outst;
    p     = out_valid && out_ready;
    outst = issued - popped;
    chk("outstanding_le2", int'(outst <= 2), 1);
    if (running)
      chk("ce1_issue", int'(ce1), int'((issued < b_len) && (outst < 2 || (outst == 2 && p))));
    else
      chk("ce1_idle", int'(ce1), 0);
    if (!busy) chk("a1_idle", int'(a1), 0);
    if (b_len == 0) chk("req_ready_len0", int'(req_ready), 1);
    if (hold) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), int'(hold_data));
    end
    if (ce1) begin
      chk("a1_addr", int'(a1), (b_addr + issued) % 1024);
      issued++;
    end
    if (p) begin
      if (popped >= b_len) chk("beat_overrun", popped + 1, b_len);
      else begin
        chk("beat_data", int'(out_data), int'(exp_q[popped]));
        chk("beat_last", int'(out_last), int'(popped == b_len - 1));
      end
      if (popped == 0) first_pop = cyc;
      if (popped == b_len - 1) last_cyc = cyc;
      popped++;
    end
    hold      = out_valid && !out_ready;
    hold_data = out_data;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic start_burst(input int addr, input int len, input int mode);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(addr + i) % 1024]);
    b_addr = addr; b_len = len; issued = 0; popped = 0; done_cnt = 0;
    first_pop = -1; last_cyc = -1; done_cyc = -1; kk = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 10'(addr); req_len = 11'(len);
    out_ready = pick(mode, kk++);
    #1;
    chk("req_ready_accept", int'(req_ready), 1);
    observe();
    running = 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_burst(input int addr, input int len, input int mode);
    int t0;
    t0 = cyc;
    start_burst(addr, len, mode);
    out_ready = pick(mode, kk++);
    #1;
    observe();
    for (int n = 0; n < len * 8 + 20 && done_cnt == 0; n++) begin
      @(negedge clk);
      out_ready = pick(mode, kk++);
      #1;
      observe();
    end
    chk("done_seen", done_cnt, 1);
    running = 0;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    observe();
    chk("done_once", done_cnt, 1);
    chk("busy_after", int'(busy), 0);
    chk("req_ready_after", int'(req_ready), 1);
    chk("beat_count", popped, len);
    chk("issue_count", issued, len);
    if (len == 0) chk("done_len0_time", done_cyc, t0 + 1);
    else begin
      chk("done_after_last", done_cyc, last_cyc + 1);
      if (mode == 0) begin
        chk("first_beat_time", first_pop, t0 + 3);
        chk("last_beat_time", last_cyc, t0 + len + 2);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'hA0 + i);
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready_after", int'(req_ready), 1);
    chk("rst_ce1", int'(ce1), 0);
    chk("rst_a1", int'(a1), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    run_burst(0, 8, 0);
    run_burst(1022, 4, 0);
    run_burst(10, 6, 1);
    run_burst(5, 0, 0);
    run_burst(700, 0, 2);

    // Abandon a burst after three beats
    start_burst(0, 8, 0);
    for (int n = 0; n < 40 && popped < 3; n++) begin
      out_ready = 1'b1;
      #1;
      observe();
      @(negedge clk);
    end
    chk("three_beats", popped, 3);
    rst = 1'b1; out_ready = 1'b0;
    #1;
    chk("midrst_req_ready", int'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_ce1", int'(ce1), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    running = 0; hold = 0; issued = 0; popped = 0; done_cnt = 0; b_len = 0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      #1;
      observe();
    end
    chk("midrst_no_done", done_cnt, 0);
    run_burst(100, 2, 0);

    run_burst(512, 1024, 0);

    for (int r = 0; r < 10; r++)
      run_burst($urandom_range(0, 1023), $urandom_range(0, 40), (r == 0) ? 1 : 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
